// File: rtl/wbq_pkg.sv
// Shared widths and the queue entry layout for the write-back queue.
package wbq_pkg;

    localparam int REG_W     = 16;
    localparam int SEL_W     = 3;
    localparam int DEPTH_MAX = 8;
    localparam int CNT_W     = 4;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [REG_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/wbq_fwd_match.sv
// Priority matcher: finds the newest occupied entry whose register select
// equals rd_sel, scanning backwards from the write pointer.
module wbq_fwd_match
    import wbq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  entry_t             entries [DEPTH],
    input  logic [DEPTH-1:0]   valid,
    input  logic [PTR_W-1:0]   wr_ptr,
    input  logic [SEL_W-1:0]   rd_sel,
    output logic               hit,
    output logic [REG_W-1:0]   data
);

    always_comb begin
        logic [PTR_W-1:0] idx;
        idx  = '0;
        hit  = 1'b0;
        data = '0;
        // k = 1 is the most recently written slot; the first match wins.
        for (int k = 1; k <= DEPTH; k++) begin
            idx = wr_ptr - PTR_W'(k);
            if (!hit && valid[idx] && (entries[idx].sel == rd_sel)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/wb_queue.sv
// Register-file write-back queue (circular FIFO) with optional read forwarding.
// Forwarding comparators are built only when WB_QUEUE_BYPASS_EN is defined.
module wb_queue
    import wbq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   in_regsel,
    input  logic [REG_W-1:0]   in_data,
    input  logic               drain_en,
    output logic               write,
    output logic [SEL_W-1:0]   writeregsel,
    output logic [REG_W-1:0]   writedata,
    output logic [CNT_W-1:0]   count,
    input  logic [SEL_W-1:0]   read1regsel,
    input  logic [SEL_W-1:0]   read2regsel,
    output logic               fwd1_hit,
    output logic               fwd2_hit,
    output logic [REG_W-1:0]   fwd1_data,
    output logic [REG_W-1:0]   fwd2_data,
    output logic               err
);

    localparam int PTR_W = $clog2(DEPTH);

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [SEL_W-1:0]   sel_prev_q, sel_prev_d;
    logic               stall_prev_q, stall_prev_d;
    logic               err_q, err_d;
    logic               push, pop, stall;

    assign in_ready = (count_q < CNT_W'(DEPTH)) && !rst;
    assign push     = in_valid && in_ready;
    assign pop      = (count_q != '0) && drain_en;
    assign stall    = in_valid && !in_ready;

    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // Only a request that was already stalled last cycle may not change.
        sel_prev_d   = in_regsel;
        stall_prev_d = stall;
        err_d        = stall && stall_prev_q && (in_regsel != sel_prev_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            sel_prev_q   <= '0;
            stall_prev_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            sel_prev_q   <= sel_prev_d;
            stall_prev_q <= stall_prev_d;
            err_q        <= err_d;
        end
    end

    // Storage is never reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{sel: in_regsel, data: in_data};
    end

    assign write       = pop;
    assign writeregsel = mem_q[rd_ptr_q].sel;
    assign writedata   = mem_q[rd_ptr_q].data;
    assign count       = count_q;
    assign err         = err_q;

`ifdef WB_QUEUE_BYPASS_EN
    logic [DEPTH-1:0] occ;

    always_comb begin
        logic [PTR_W-1:0] ofs;
        ofs = '0;
        occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ofs    = PTR_W'(i) - rd_ptr_q;
            occ[i] = CNT_W'(ofs) < count_q;
        end
    end

    wbq_fwd_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fwd1 (
        .entries (mem_q),
        .valid   (occ),
        .wr_ptr  (wr_ptr_q),
        .rd_sel  (read1regsel),
        .hit     (fwd1_hit),
        .data    (fwd1_data)
    );

    wbq_fwd_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fwd2 (
        .entries (mem_q),
        .valid   (occ),
        .wr_ptr  (wr_ptr_q),
        .rd_sel  (read2regsel),
        .hit     (fwd2_hit),
        .data    (fwd2_data)
    );
`else
    logic unused_rd_sel;
    assign unused_rd_sel = ^{read1regsel, read2regsel};
    assign fwd1_hit      = 1'b0;
    assign fwd2_hit      = 1'b0;
    assign fwd1_data     = 16'h0000;
    assign fwd2_data     = 16'h0000;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue (DEPTH=4); forwarding expectations follow WB_QUEUE_BYPASS_EN.
module tb_wb_queue;

`ifdef WB_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_regsel;
    logic [15:0] in_data;
    logic        drain_en;
    logic        write;
    logic [2:0]  writeregsel;
    logic [15:0] writedata;
    logic [3:0]  count;
    logic [2:0]  read1regsel, read2regsel;
    logic        fwd1_hit, fwd2_hit;
    logic [15:0] fwd1_data, fwd2_data;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [2:0]  fill_sel [4] = '{3'd1, 3'd2, 3'd5, 3'd7};
    logic [15:0] fill_dat [4] = '{16'hA001, 16'hA002, 16'hA005, 16'hA007};
    logic [2:0]  drn_sel  [4] = '{3'd2, 3'd5, 3'd7, 3'd7};
    logic [15:0] drn_dat  [4] = '{16'hA002, 16'hA005, 16'hA007, 16'h5555};

    always #5 clk = ~clk;

    wb_queue #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_regsel   (in_regsel),
        .in_data     (in_data),
        .drain_en    (drain_en),
        .write       (write),
        .writeregsel (writeregsel),
        .writedata   (writedata),
        .count       (count),
        .read1regsel (read1regsel),
        .read2regsel (read2regsel),
        .fwd1_hit    (fwd1_hit),
        .fwd2_hit    (fwd2_hit),
        .fwd1_data   (fwd1_data),
        .fwd2_data   (fwd2_data),
        .err         (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_regsel = '0; in_data = '0;
        drain_en = 1'b1; read1regsel = '0; read2regsel = '0;
        tick(); tick(); #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_count", count, 0);
        chk("rst_write", write, 0);
        chk("rst_err", err, 0);
        rst = 1'b0; #1;
        chk("post_rst_ready", in_ready, 1);
        chk("post_rst_write", write, 0);
        chk("post_rst_fwd1", fwd1_hit, 0);

        // single push, drained the following cycle
        in_valid = 1'b1; in_regsel = 3'd3; in_data = 16'hBEEF; #1;
        chk("no_passthru", write, 0);
        tick(); in_valid = 1'b0; #1;
        chk("one_count", count, 1);
        chk("one_write", write, 1);
        chk("one_sel", writeregsel, 3);
        chk("one_data", writedata, 16'hBEEF);
        tick(); #1;
        chk("one_empty", count, 0);
        chk("one_idle", write, 0);

        // fill to full, fifth request stalls
        drain_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_regsel = fill_sel[i]; in_data = fill_dat[i]; #1;
            chk("fill_ready", in_ready, 1);
            tick();
        end
        in_regsel = 3'd7; in_data = 16'h5555; #1;
        chk("full_count", count, 4);
        chk("full_ready", in_ready, 0);
        chk("full_write", write, 0);
        tick(); #1;
        chk("held_count", count, 4);
        chk("held_err", err, 0);
        tick(); #1;
        chk("held_err2", err, 0);
        chk("held_ready", in_ready, 0);

        // pop while full: slot is not refilled in the same cycle
        drain_en = 1'b1; #1;
        chk("fullpop_write", write, 1);
        chk("fullpop_sel", writeregsel, 1);
        chk("fullpop_data", writedata, 16'hA001);
        tick(); drain_en = 1'b0; #1;
        chk("after_pop_count", count, 3);
        chk("after_pop_ready", in_ready, 1);
        chk("after_pop_head", writeregsel, 2);
        tick(); in_valid = 1'b0; #1;
        chk("refill_count", count, 4);
        drain_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_write", write, 1);
            chk("drain_sel", writeregsel, drn_sel[i]);
            chk("drain_data", writedata, drn_dat[i]);
            tick();
        end
        #1;
        chk("drained_count", count, 0);
        chk("drained_write", write, 0);
        tick(); #1;
        chk("idle_drain_count", count, 0);

        // forwarding
        drain_en = 1'b0; read1regsel = 3'd2; read2regsel = 3'd5;
        in_valid = 1'b1; in_regsel = 3'd2; in_data = 16'h1111; #1;
        chk("fwd_push_excl", fwd1_hit, 0);
        tick(); in_data = 16'h2222; #1;
        chk("fwd_first_hit", fwd1_hit, BYP);
        chk("fwd_first_data", fwd1_data, BYP ? 16'h1111 : 16'h0000);
        tick(); in_regsel = 3'd5; in_data = 16'h3333; #1;
        chk("fwd_newest_hit", fwd1_hit, BYP);
        chk("fwd_newest_data", fwd1_data, BYP ? 16'h2222 : 16'h0000);
        chk("fwd2_miss", fwd2_hit, 0);
        tick(); in_valid = 1'b0; #1;
        chk("fwd2_hit", fwd2_hit, BYP);
        chk("fwd2_data", fwd2_data, BYP ? 16'h3333 : 16'h0000);
        chk("fwd_count", count, 3);
        drain_en = 1'b1;
        tick(); #1;
        chk("fwd_pop_count", count, 2);
        chk("fwd_head_data", writedata, 16'h2222);
        chk("fwd_head_hit", fwd1_hit, BYP);
        chk("fwd_head_fdata", fwd1_data, BYP ? 16'h2222 : 16'h0000);
        tick(); drain_en = 1'b0; #1;
        chk("fwd_gone_count", count, 1);
        chk("fwd_gone_hit", fwd1_hit, 0);
        chk("fwd2_still", fwd2_hit, BYP);

        // reset mid-operation
        in_valid = 1'b1; in_regsel = 3'd3; in_data = 16'h0AAA;
        tick(); in_regsel = 3'd4; in_data = 16'h0BBB;
        tick(); in_valid = 1'b0; #1;
        chk("pre_rst_count", count, 3);
        rst = 1'b1; drain_en = 1'b1; #1;
        chk("rst_ready_low", in_ready, 0);
        tick(); #1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_write", write, 0);
        chk("mid_rst_ready", in_ready, 0);
        tick(); rst = 1'b0; #1;
        chk("rel_ready", in_ready, 1);
        chk("rel_count", count, 0);
        chk("rel_write", write, 0);
        tick(); #1;
        chk("rel_no_write", write, 0);

        // stalled request changes its select
        drain_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_regsel = 3'd1; in_data = 16'(i);
            tick();
        end
        in_data = 16'h0101; #1;
        chk("stall_ready", in_ready, 0);
        chk("stall_err0", err, 0);
        tick(); #1;
        chk("stall_err1", err, 0);
        in_regsel = 3'd6;
        tick(); #1;
        chk("err_pulse", err, 1);
        tick(); #1;
        chk("err_cleared", err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
